// File: rtl/axi4_slave_write_ctrl_if.sv
// AXI4 write-channel bundle (AW, W, B) between a write master and the slave front end.
interface axi4_slave_write_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WLAST, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/axi4_slave_write_ctrl.sv
// AXI4 slave write front end: one AW burst at a time, one memory word write per W beat,
// one B response per burst; illegal bursts are drained without writing and answered SLVERR.
module axi4_slave_write_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_DEPTH  = 4096
) (
  input  logic                          clk,
  input  logic                          ARESTN,
  axi4_slave_write_ctrl_if.slave        s_axi,
  output logic                          mem_we,
  output logic [$clog2(MEM_DEPTH)-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [DATA_WIDTH/8-1:0]       mem_wstrb
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned BSHIFT = $clog2(NBYTES);
  localparam int unsigned MAW    = $clog2(MEM_DEPTH);
  localparam int unsigned LW     = ADDR_WIDTH + 17;
  localparam int unsigned SW     = 2 * NBYTES;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q;
  logic [7:0]            cnt_q;
  logic                  err_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs_c;
  logic                  w_hs_c;
  logic                  b_hs_c;
  logic                  cnt_done_c;
  logic                  last_beat_c;
  logic                  wlast_err_c;
  logic                  aw_err_c;
  logic [16:0]           bytes_c;
  logic [16:0]           end4k_c;
  logic [LW-1:0]         last_byte_c;
  logic [SW-1:0]         strb_wide_c;

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;

  // Burst legality, handshakes, lane mask and next state
  always_comb begin
    bytes_c     = (17'(s_axi.AWLEN) + 17'd1) << s_axi.AWSIZE;
    end4k_c     = 17'(s_axi.AWADDR[11:0]) + bytes_c;
    last_byte_c = LW'(s_axi.AWADDR) + LW'(bytes_c) - LW'(1);
    aw_err_c    = (end4k_c > 17'd4096)
               || (32'(s_axi.AWSIZE) > BSHIFT)
               || ((last_byte_c >> BSHIFT) >= LW'(MEM_DEPTH));

    aw_hs_c     = s_axi.AWVALID & awready_q;
    w_hs_c      = s_axi.WVALID & wready_q;
    b_hs_c      = bvalid_q & s_axi.BREADY;
    cnt_done_c  = (cnt_q == len_q);
    last_beat_c = cnt_done_c | s_axi.WLAST;
    wlast_err_c = cnt_done_c ^ s_axi.WLAST;
    strb_wide_c = ((SW'(1) << (8'd1 << size_q)) - SW'(1))
                  << (addr_q & ADDR_WIDTH'(NBYTES - 1));

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (aw_hs_c) state_d = DATA;
      DATA:    if (w_hs_c && last_beat_c) state_d = RESP;
      RESP:    if (b_hs_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge ARESTN) begin
    if (!ARESTN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Handshake outputs follow the next state so they change on the same edge as the FSM
  always_ff @(posedge clk or negedge ARESTN) begin
    if (!ARESTN) begin
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we    <= 1'b0;
      awready_q <= (state_d == IDLE);
      wready_q  <= (state_d == DATA);
      bvalid_q  <= (state_d == RESP);

      if (state_q == IDLE && aw_hs_c) begin
        addr_q <= s_axi.AWADDR;
        len_q  <= s_axi.AWLEN;
        size_q <= s_axi.AWSIZE;
        cnt_q  <= 8'd0;
        err_q  <= aw_err_c;
      end

      if (state_q == DATA && w_hs_c) begin
        if (!err_q) begin
          mem_we    <= 1'b1;
          mem_addr  <= MAW'(addr_q >> BSHIFT);
          mem_wdata <= s_axi.WDATA;
          mem_wstrb <= NBYTES'(strb_wide_c);
        end
        addr_q <= addr_q + (ADDR_WIDTH'(1) << size_q);
        cnt_q  <= cnt_q + 8'd1;
        if (wlast_err_c) err_q <= 1'b1;
        if (last_beat_c) bresp_q <= (err_q || wlast_err_c) ? SLVERR : OKAY;
      end

      if (state_q == RESP && b_hs_c) bresp_q <= OKAY;
    end
  end

endmodule

// File: tb/tb_axi4_slave_write_ctrl.sv
// Directed self-checking bench for axi4_slave_write_ctrl with hand-computed expectations.
module tb_axi4_slave_write_ctrl;

  logic        clk;
  logic        ARESTN;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks;
  int errors;

  logic [11:0] wq_a[$];
  logic [31:0] wq_d[$];
  logic [3:0]  wq_s[$];

  axi4_slave_write_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  axi4_slave_write_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .MEM_DEPTH(4096)) dut (
    .clk       (clk),
    .ARESTN    (ARESTN),
    .s_axi     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every memory write pulse
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wq_a.push_back(mem_addr);
      wq_d.push_back(mem_wdata);
      wq_s.push_back(mem_wstrb);
    end
  end

  task automatic aw_send(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size);
    int n;
    bus.AWADDR = addr; bus.AWLEN = len; bus.AWSIZE = size; bus.AWVALID = 1'b1;
    n = 0;
    while (bus.AWREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.AWREADY !== 1'b1) begin
      errors++; $display("FAIL aw_timeout AWREADY=%b required 1", bus.AWREADY);
    end
    @(negedge clk);
    bus.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic last);
    int n;
    bus.WDATA = data; bus.WLAST = last; bus.WVALID = 1'b1;
    n = 0;
    while (bus.WREADY !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.WREADY !== 1'b1) begin
      errors++; $display("FAIL w_timeout WREADY=%b required 1", bus.WREADY);
    end
    @(negedge clk);
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp);
    int n;
    bus.BREADY = 1'b1;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus.BVALID !== 1'b1) begin
      errors++; $display("FAIL b_timeout BVALID=%b required 1", bus.BVALID);
    end
    resp = bus.BRESP;
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic run_burst(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input int nbeats, input int gap, input int wlast_idx,
                           input logic [31:0] dbase, input logic [31:0] dstep,
                           output logic [1:0] resp);
    wq_a.delete(); wq_d.delete(); wq_s.delete();
    aw_send(addr, len, size);
    for (int i = 0; i < nbeats; i++) begin
      w_send(dbase + dstep * 32'(i), i == wlast_idx);
      repeat (gap) @(negedge clk);
    end
    b_take(resp);
  endtask

  task automatic test_reset;
    ARESTN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.AWREADY !== 1'b0) begin errors++; $display("FAIL rst_awready got %b want 0", bus.AWREADY); end
    checks++; if (bus.WREADY !== 1'b0) begin errors++; $display("FAIL rst_wready got %b want 0", bus.WREADY); end
    checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b want 0", bus.BVALID); end
    checks++; if (bus.BRESP !== 2'b00) begin errors++; $display("FAIL rst_bresp got %b want 00", bus.BRESP); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    checks++; if (mem_addr !== 12'h0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL rst_mem_wstrb got %h want 0", mem_wstrb); end
    ARESTN = 1'b1;
    @(negedge clk);
    checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL rst_release_awready got %b want 1", bus.AWREADY); end
  endtask

  task automatic test_aligned_4k_end;
    logic [1:0] resp;
    run_burst(16'h0FE0, 8'd7, 3'd2, 8, 1, 7, 32'h1, 32'h1, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL aligned_bresp got %b want 00", resp); end
    checks++;
    if (wq_a.size() != 8) begin errors++; $display("FAIL aligned_count got %0d want 8", wq_a.size()); end
    else for (int i = 0; i < 8; i++) begin
      checks++;
      if (wq_a[i] !== 12'h3F8 + 12'(i) || wq_d[i] !== 32'(i + 1) || wq_s[i] !== 4'hF) begin
        errors++;
        $display("FAIL aligned_beat%0d got a=%h d=%h s=%h want a=%h d=%h s=f",
                 i, wq_a[i], wq_d[i], wq_s[i], 12'h3F8 + 12'(i), 32'(i + 1));
      end
    end
  endtask

  task automatic test_4k_cross;
    logic [1:0] resp;
    run_burst(16'h0FF0, 8'd7, 3'd2, 8, 0, 7, 32'h10, 32'h1, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL cross4k_bresp got %b want 10", resp); end
    checks++; if (wq_a.size() != 0) begin errors++; $display("FAIL cross4k_writes got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_narrow_and_oversize;
    logic [1:0] resp;
    run_burst(16'h0002, 8'd1, 3'd1, 2, 0, 1, 32'hAAAA, 32'h1111, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL narrow_bresp got %b want 00", resp); end
    checks++;
    if (wq_a.size() != 2) begin errors++; $display("FAIL narrow_count got %0d want 2", wq_a.size()); end
    else begin
      checks++;
      if (wq_a[0] !== 12'h0 || wq_d[0] !== 32'hAAAA || wq_s[0] !== 4'hC) begin
        errors++; $display("FAIL narrow_beat0 got a=%h d=%h s=%h want a=0 d=aaaa s=c", wq_a[0], wq_d[0], wq_s[0]);
      end
      checks++;
      if (wq_a[1] !== 12'h1 || wq_d[1] !== 32'hBBBB || wq_s[1] !== 4'h3) begin
        errors++; $display("FAIL narrow_beat1 got a=%h d=%h s=%h want a=1 d=bbbb s=3", wq_a[1], wq_d[1], wq_s[1]);
      end
    end
    run_burst(16'h0000, 8'd1, 3'd3, 2, 0, 1, 32'h5, 32'h1, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL oversize_bresp got %b want 10", resp); end
    checks++; if (wq_a.size() != 0) begin errors++; $display("FAIL oversize_writes got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_range;
    logic [1:0] resp;
    run_burst(16'h3FFC, 8'd0, 3'd2, 1, 0, 0, 32'hCAFE, 32'h0, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL range_top_bresp got %b want 00", resp); end
    checks++;
    if (wq_a.size() != 1 || wq_a[0] !== 12'hFFF) begin
      errors++; $display("FAIL range_top_write got count=%0d want 1 at fff", wq_a.size());
    end
    run_burst(16'h4000, 8'd0, 3'd2, 1, 0, 0, 32'hBEEF, 32'h0, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL range_out_bresp got %b want 10", resp); end
    checks++; if (wq_a.size() != 0) begin errors++; $display("FAIL range_out_writes got %0d want 0", wq_a.size()); end
  endtask

  task automatic test_wlast_mismatch;
    logic [1:0] resp;
    run_burst(16'h0100, 8'd3, 3'd2, 2, 0, 1, 32'h100, 32'h1, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL early_bresp got %b want 10", resp); end
    checks++;
    if (wq_a.size() != 2 || wq_a[0] !== 12'h40 || wq_a[1] !== 12'h41 || wq_d[1] !== 32'h101) begin
      errors++; $display("FAIL early_writes got count=%0d want 2 at 40,41", wq_a.size());
    end
    run_burst(16'h0200, 8'd3, 3'd2, 4, 0, -1, 32'h200, 32'h1, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL nolast_bresp got %b want 10", resp); end
    checks++;
    if (wq_a.size() != 4 || wq_a[3] !== 12'h83 || wq_d[3] !== 32'h203) begin
      errors++; $display("FAIL nolast_writes got count=%0d want 4 ending at 83", wq_a.size());
    end
  endtask

  task automatic test_bready_stall;
    logic [1:0] resp;
    int n;
    wq_a.delete(); wq_d.delete(); wq_s.delete();
    aw_send(16'h0010, 8'd0, 3'd2);
    w_send(32'h55, 1'b1);
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== 2'b00 || bus.AWREADY !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d got bvalid=%b bresp=%b awready=%b want 1 00 0",
                 i, bus.BVALID, bus.BRESP, bus.AWREADY);
      end
      @(negedge clk);
    end
    b_take(resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL stall_bresp got %b want 00", resp); end
    checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("FAIL stall_bvalid_drop got %b want 0", bus.BVALID); end
    checks++;
    if (wq_a.size() != 1 || wq_a[0] !== 12'h4 || wq_d[0] !== 32'h55) begin
      errors++; $display("FAIL stall_write got count=%0d want 1 at 4", wq_a.size());
    end
  endtask

  task automatic test_reset_mid_burst;
    logic [1:0] resp;
    wq_a.delete(); wq_d.delete(); wq_s.delete();
    aw_send(16'h0300, 8'd7, 3'd2);
    for (int i = 0; i < 3; i++) w_send(32'h31 + 32'(i), 1'b0);
    @(negedge clk);
    bus.WDATA = 32'h34; bus.WVALID = 1'b1;
    ARESTN = 1'b0;
    repeat (2) @(negedge clk);
    bus.WVALID = 1'b0;
    ARESTN = 1'b1;
    @(negedge clk);
    checks++; if (bus.AWREADY !== 1'b1) begin errors++; $display("FAIL midrst_awready got %b want 1", bus.AWREADY); end
    repeat (3) begin
      checks++; if (bus.BVALID !== 1'b0) begin errors++; $display("FAIL midrst_bvalid got %b want 0", bus.BVALID); end
      @(negedge clk);
    end
    checks++;
    if (wq_a.size() != 3 || wq_a[2] !== 12'hC2 || wq_d[2] !== 32'h33) begin
      errors++; $display("FAIL midrst_writes got count=%0d want 3 ending at c2", wq_a.size());
    end
    run_burst(16'h0020, 8'd1, 3'd2, 2, 0, 1, 32'h11, 32'h11, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL after_rst_bresp got %b want 00", resp); end
    checks++;
    if (wq_a.size() != 2 || wq_a[0] !== 12'h8 || wq_a[1] !== 12'h9 || wq_d[1] !== 32'h22) begin
      errors++; $display("FAIL after_rst_writes got count=%0d want 2 at 8,9", wq_a.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    test_reset;
    test_aligned_4k_end;
    test_4k_cross;
    test_narrow_and_oversize;
    test_range;
    test_wlast_mismatch;
    test_bready_stall;
    test_reset_mid_burst;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
